// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, data/strobe widths and the
// master FSM state encoding used by axi4_lite_master_if.
package axi4_lite_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } mst_state_e;

endpackage

// File: rtl/axi4_lite_master_if.sv
// Single-outstanding AXI4-Lite master: cmd/rsp register access -> AXI4-Lite.
// Ports: clk, rst (sync, active-high); cmd_* command in; rsp_* response out;
// m_axi_* AXI4-Lite master channels. Optional err_cnt output when the macro
// AXI4_LITE_MASTER_ERRCNT_EN is defined (counts non-OKAY responses).
module axi4_lite_master_if
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [DATA_W-1:0]    cmd_wdata,
    input  logic [STRB_W-1:0]    cmd_wstrb,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic [1:0]           rsp_resp,
`ifdef AXI4_LITE_MASTER_ERRCNT_EN
    output logic [15:0]          err_cnt,
`endif
    output logic [ADDR_BITS-1:0] m_axi_awaddr,
    output logic [2:0]           m_axi_awprot,
    output logic                 m_axi_awvalid,
    input  logic                 m_axi_awready,
    output logic [DATA_W-1:0]    m_axi_wdata,
    output logic [STRB_W-1:0]    m_axi_wstrb,
    output logic                 m_axi_wvalid,
    input  logic                 m_axi_wready,
    input  logic [1:0]           m_axi_bresp,
    input  logic                 m_axi_bvalid,
    output logic                 m_axi_bready,
    output logic [ADDR_BITS-1:0] m_axi_araddr,
    output logic [2:0]           m_axi_arprot,
    output logic                 m_axi_arvalid,
    input  logic                 m_axi_arready,
    input  logic [DATA_W-1:0]    m_axi_rdata,
    input  logic [1:0]           m_axi_rresp,
    input  logic                 m_axi_rvalid,
    output logic                 m_axi_rready
);

    mst_state_e             state_q, state_d;
    logic                   aw_done_q, aw_done_d;
    logic                   w_done_q, w_done_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [STRB_W-1:0]      wstrb_q, wstrb_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [1:0]             resp_q, resp_d;
    logic                   aw_hs, w_hs;

    // All valids/readies decode from flops only, never from a ready input.
    assign cmd_ready     = (state_q == IDLE);
    assign rsp_valid     = (state_q == RSP);
    assign m_axi_awvalid = (state_q == WR_REQ) && !aw_done_q;
    assign m_axi_wvalid  = (state_q == WR_REQ) && !w_done_q;
    assign m_axi_bready  = (state_q == WR_RESP);
    assign m_axi_arvalid = (state_q == RD_REQ);
    assign m_axi_rready  = (state_q == RD_DATA);

    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = wstrb_q;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign rsp_rdata    = rdata_q;
    assign rsp_resp     = resp_q;

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_we ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                // Both handshakes may land in the same or different cycles.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs))
                    state_d = WR_RESP;
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    resp_d  = m_axi_bresp;
                    rdata_d = '0;
                    state_d = RSP;
                end
            end
            RD_REQ: begin
                if (m_axi_arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (m_axi_rvalid) begin
                    rdata_d = m_axi_rdata;
                    resp_d  = m_axi_rresp;
                    state_d = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

`ifdef AXI4_LITE_MASTER_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        err_evt;

    assign err_evt =
        (m_axi_bready && m_axi_bvalid && (m_axi_bresp != RESP_OKAY)) ||
        (m_axi_rready && m_axi_rvalid && (m_axi_rresp != RESP_OKAY));

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_evt && (err_cnt_q != 16'hFFFF))
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_axi4_lite_master_if.sv
// Self-checking bench for axi4_lite_master_if: directed table, hand-written
// reset sequence and randomized transactions against a slave/response model.
module tb_axi4_lite_master_if;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_lat;
        int          w_lat;
        int          b_lat;
        int          ar_lat;
        int          r_lat;
        logic [1:0]  slv_resp;
        logic [31:0] slv_rdata;
        int          rsp_hold;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;
`ifdef AXI4_LITE_MASTER_ERRCNT_EN
    logic [15:0] err_cnt;
    int          err_model;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi4_lite_master_if #(.ADDR_BITS(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_we(cmd_we), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
`ifdef AXI4_LITE_MASTER_ERRCNT_EN
        .err_cnt(err_cnt),
`endif
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(bit we, logic [31:0] addr, logic [31:0] wd,
                                int awl, int wl, int bl, int arl, int rl,
                                logic [1:0] rs, logic [31:0] rd, int hold,
                                logic [31:0] erd, logic [1:0] ers, int elat);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wd; v.wstrb = 4'hF;
        v.aw_lat = awl; v.w_lat = wl; v.b_lat = bl;
        v.ar_lat = arl; v.r_lat = rl;
        v.slv_resp = rs; v.slv_rdata = rd; v.rsp_hold = hold;
        v.exp_rdata = erd; v.exp_resp = ers; v.exp_lat = elat;
        return v;
    endfunction

    task automatic idle_slave();
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0;
    endtask

    // Drives one command and plays the slave; all on negedges.
    task automatic run_txn(input vec_t t);
        int cyc = 0;
        int lat = 1;
        bit done = 0, seen = 0;
        bit aw_got = 0, w_got = 0, b_done = 0, ar_got = 0, r_done = 0;
        int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0, hold_c = 0;
        logic [31:0] rd0;
        logic [1:0]  rs0;
        rd0 = '0; rs0 = '0;
        while (!cmd_ready && cyc < 50) begin
            @(negedge clk); cyc++;
        end
        chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1; cmd_we = t.we; cmd_addr = t.addr;
        cmd_wdata = t.wdata; cmd_wstrb = t.wstrb;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_addr = $urandom;
        cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
        while (!done && lat < 300) begin
            // B channel
            m_axi_bvalid = 1'b0; m_axi_bresp = 2'($urandom);
            if (m_axi_bready)
                chk("bready_early", {63'd0, aw_got && w_got && !b_done}, 1);
            if (aw_got && w_got && !b_done) begin
                if (b_c >= t.b_lat) begin
                    m_axi_bvalid = 1'b1; m_axi_bresp = t.slv_resp;
                    if (m_axi_bready) b_done = 1;
                end else b_c++;
            end
            // R channel
            m_axi_rvalid = 1'b0; m_axi_rresp = 2'($urandom);
            m_axi_rdata = $urandom;
            if (m_axi_rready)
                chk("rready_early", {63'd0, ar_got && !r_done}, 1);
            if (ar_got && !r_done) begin
                if (r_c >= t.r_lat) begin
                    m_axi_rvalid = 1'b1; m_axi_rresp = t.slv_resp;
                    m_axi_rdata = t.slv_rdata;
                    if (m_axi_rready) r_done = 1;
                end else r_c++;
            end
            // AW / W / AR
            m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
            if (m_axi_awvalid) begin
                chk("awvalid_after_hs", {63'd0, aw_got}, 0);
                chk("awaddr", {32'd0, m_axi_awaddr}, {32'd0, t.addr});
                if (aw_c >= t.aw_lat) begin
                    m_axi_awready = 1'b1; aw_got = 1;
                end else aw_c++;
            end
            if (m_axi_wvalid) begin
                chk("wvalid_after_hs", {63'd0, w_got}, 0);
                chk("wdata", {28'd0, m_axi_wstrb, m_axi_wdata},
                    {28'd0, t.wstrb, t.wdata});
                if (w_c >= t.w_lat) begin
                    m_axi_wready = 1'b1; w_got = 1;
                end else w_c++;
            end
            if (m_axi_arvalid) begin
                chk("arvalid_after_hs", {63'd0, ar_got}, 0);
                chk("araddr", {32'd0, m_axi_araddr}, {32'd0, t.addr});
                if (ar_c >= t.ar_lat) begin
                    m_axi_arready = 1'b1; ar_got = 1;
                end else ar_c++;
            end
            // Response side
            rsp_ready = 1'b0;
            if (rsp_valid) begin
                if (!seen) begin
                    seen = 1; rd0 = rsp_rdata; rs0 = rsp_resp;
                    chk("rsp_latency", 64'(lat), 64'(t.exp_lat));
                    chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, t.exp_rdata});
                    chk("rsp_resp", {62'd0, rsp_resp}, {62'd0, t.exp_resp});
                end else begin
                    chk("rsp_stable", {30'd0, rsp_resp, rsp_rdata},
                        {30'd0, rs0, rd0});
                end
                chk("axi_quiet_in_rsp",
                    {59'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                     m_axi_bready, m_axi_rready}, 64'd0);
                if (hold_c >= t.rsp_hold) begin
                    rsp_ready = 1'b1; done = 1;
                end else hold_c++;
            end
            chk("cmd_ready_busy", {63'd0, cmd_ready}, 0);
            @(negedge clk); lat++;
        end
        chk("txn_done", {63'd0, done}, 1);
        rsp_ready = 1'b0;
        idle_slave();
        chk("cmd_ready_after", {63'd0, cmd_ready}, 1);
        chk("rsp_valid_after", {63'd0, rsp_valid}, 0);
`ifdef AXI4_LITE_MASTER_ERRCNT_EN
        if (t.slv_resp != 2'b00 && err_model < 16'hFFFF) err_model++;
`endif
    endtask

    vec_t vecs[8];
    vec_t rv;

    initial begin
        int cyc;
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        m_axi_bresp = '0; m_axi_rresp = '0; m_axi_rdata = '0;
        idle_slave();
`ifdef AXI4_LITE_MASTER_ERRCNT_EN
        err_model = 0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 1);
        chk("rst_rsp", {29'd0, rsp_valid, rsp_resp, rsp_rdata}, 64'd0);
        chk("rst_valids",
            {59'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
             m_axi_bready, m_axi_rready}, 64'd0);
        chk("rst_addr", {m_axi_awaddr, m_axi_araddr}, 64'd0);
        chk("rst_wdata", {28'd0, m_axi_wstrb, m_axi_wdata}, 64'd0);
        chk("prot", {58'd0, m_axi_awprot, m_axi_arprot}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        vecs[0] = mk(1, 32'h4, 32'hDEADBEEF, 0, 0, 0, 0, 0,
                     2'b00, 32'h0, 0, 32'h0, 2'b00, 3);
        vecs[1] = mk(0, 32'h8, 32'h0, 0, 0, 0, 5, 3,
                     2'b00, 32'h12345678, 0, 32'h12345678, 2'b00, 11);
        vecs[2] = mk(1, 32'h10, 32'hA5A5_0001, 4, 0, 0, 0, 0,
                     2'b00, 32'h0, 0, 32'h0, 2'b00, 7);
        vecs[3] = mk(1, 32'h14, 32'hA5A5_0002, 0, 4, 0, 0, 0,
                     2'b00, 32'h0, 0, 32'h0, 2'b00, 7);
        vecs[4] = mk(0, 32'h20, 32'h0, 0, 0, 0, 0, 0,
                     2'b10, 32'hCAFEF00D, 0, 32'hCAFEF00D, 2'b10, 3);
        vecs[5] = mk(1, 32'h24, 32'h5555_AAAA, 0, 0, 0, 0, 0,
                     2'b11, 32'h0, 0, 32'h0, 2'b11, 3);
        vecs[6] = mk(1, 32'h28, 32'h0BAD_F00D, 0, 0, 0, 0, 0,
                     2'b00, 32'h0, 10, 32'h0, 2'b00, 3);
        vecs[7] = mk(0, 32'h2C, 32'h0, 0, 0, 0, 0, 0,
                     2'b00, 32'h7777_1111, 0, 32'h7777_1111, 2'b00, 3);
        for (int i = 0; i < 8; i++) run_txn(vecs[i]);
`ifdef AXI4_LITE_MASTER_ERRCNT_EN
        chk("err_cnt_table", {48'd0, err_cnt}, 64'd2);
`endif

        // Randomized traffic; expected values follow the protocol rules.
        for (int i = 0; i < 40; i++) begin
            rv.we = 1'($urandom);
            rv.addr = $urandom & 32'hFFFF_FFFC;
            rv.wdata = $urandom;
            rv.wstrb = 4'($urandom);
            rv.aw_lat = $urandom_range(0, 3);
            rv.w_lat = $urandom_range(0, 3);
            rv.b_lat = $urandom_range(0, 3);
            rv.ar_lat = $urandom_range(0, 3);
            rv.r_lat = $urandom_range(0, 3);
            rv.slv_resp = 2'($urandom);
            rv.slv_rdata = $urandom;
            rv.rsp_hold = $urandom_range(0, 2);
            rv.exp_rdata = rv.we ? 32'h0 : rv.slv_rdata;
            rv.exp_resp = rv.slv_resp;
            if (rv.we)
                rv.exp_lat = 3 + rv.b_lat +
                    ((rv.aw_lat > rv.w_lat) ? rv.aw_lat : rv.w_lat);
            else
                rv.exp_lat = 3 + rv.ar_lat + rv.r_lat;
            run_txn(rv);
        end
`ifdef AXI4_LITE_MASTER_ERRCNT_EN
        chk("err_cnt_random", {48'd0, err_cnt}, 64'(err_model));
`endif

        // Reset while waiting for B.
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h30;
        cmd_wdata = 32'h1234_0000; cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        @(negedge clk);
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        cyc = 0;
        while (!m_axi_bready && cyc < 20) begin
            @(negedge clk); cyc++;
        end
        chk("wr_resp_reached", {63'd0, m_axi_bready}, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_valids",
            {59'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
             m_axi_bready, m_axi_rready}, 64'd0);
        chk("rst_mid_cmd_ready", {63'd0, cmd_ready}, 1);
        chk("rst_mid_rsp_valid", {63'd0, rsp_valid}, 0);
`ifdef AXI4_LITE_MASTER_ERRCNT_EN
        err_model = 0;
        chk("rst_mid_err_cnt", {48'd0, err_cnt}, 64'd0);
`endif
        run_txn(mk(0, 32'h34, 32'h0, 0, 0, 0, 1, 1,
                   2'b00, 32'h600D_0001, 0, 32'h600D_0001, 2'b00, 5));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master_if.md
# axi4_lite_master_if

Single-outstanding AXI4-Lite master that turns a simple command/response register-access interface into AXI4-Lite write and read transactions. It is the initiator counterpart of the slave-side register interface used by our custom peripherals. It lets in-fabric logic (DMA sequencers, self-test engines) program and read AXI4-Lite peripherals without a processor.

## Interface
Parameters:
- ADDR_BITS, 32, width of cmd_addr and m_axi_awaddr/araddr.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_BITS  byte address.
- cmd_wdata  in  32  write data; ignored for reads.
- cmd_wstrb  in  4  byte enables; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP of the completed transaction.
- m_axi_awaddr/awprot/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arprot/arvalid/arready, m_axi_rdata/rresp/rvalid/rready: standard AXI4-Lite master channels, 32-bit data. awprot and arprot are tied to 3'b000.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: cmd_ready=1. On accept, latch addr/data/strb/we. Go to WR_REQ if we=1, otherwise RD_REQ.
- WR_REQ: awvalid and wvalid assert together. Each drops independently after its own handshake, tracked by aw_done/w_done flags. When both handshakes are done (same or different cycles), go to WR_RESP.
- WR_RESP: bready=1. On bvalid, latch bresp and set rdata=0. Go to RSP.
- RD_REQ: arvalid=1. On arready, go to RD_DATA.
- RD_DATA: rready=1. On rvalid, latch rdata/rresp. Go to RSP.
- RSP: rsp_valid=1, held with stable data until rsp_ready. Then go to IDLE.
- Only one transaction is in flight; no new command is accepted until the response is consumed.
- Every valid is registered and never depends combinationally on the matching ready. A valid stays asserted, with stable payload, until its handshake completes.
- A non-OKAY response is passed through unchanged. The block does not retry.
- Reset in any state: on the next edge, go to IDLE and clear all valids/readies and flags. The system resets the interconnect together with this block.

## Timing
Reset values:
- cmd_ready=1 (IDLE).
- rsp_valid=0, rsp_rdata=0, rsp_resp=0.
- awvalid=wvalid=arvalid=0.
- bready=rready=0.
- Address/data outputs 0.

Cycle-level behaviour:
- Command accepted at edge N: awvalid/wvalid or arvalid high from cycle N+1.
- Best case, with slave readies high and B/R returned one cycle after the address: rsp_valid at N+3. Total command-to-command throughput is 4 cycles.
- AW and W may complete in either order. A W handshake before AW holds wvalid low while awvalid stays high.
- bready/rready assert the cycle after entering WR_RESP/RD_DATA, not earlier.
- cmd_ready is low from N+1 until the cycle after the rsp handshake.

## Configuration
- AXI4_LITE_MASTER_ERRCNT_EN defined: adds output err_cnt [15:0].
  - It increments on each completed transaction with resp != OKAY and saturates at 16'hFFFF.
  - rst clears it; no other clear.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package axi4_lite_pkg holds:
  - response codes RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - master state enum;
  - data width constant 32 and strobe width 4.
- No sub-module; the FSM and latches form one module. The optional counter is inline.

## Test plan
- Write 0x4 ← 0xDEADBEEF, strb 4'hF, slave readies always high → AW/W handshakes in cycle N+1, rsp_valid at N+3, rsp_resp=0, rsp_rdata=0.
- Read 0x8, slave returns 0x12345678 after 5 wait cycles on arready and 3 on rvalid → arvalid held stable throughout, rsp_rdata=0x12345678.
- Write with wready 4 cycles before awready, then the reverse order → wvalid drops after its own handshake, exactly one B wait, one response.
- Slave returns SLVERR on a read and DECERR on a write → rsp_resp=2'b10 then 2'b11. With AXI4_LITE_MASTER_ERRCNT_EN, err_cnt=2.
- rsp_ready held low 10 cycles → rsp_valid and data stable, cmd_ready=0, no AXI activity. Then back-to-back commands proceed.
- rst asserted during WR_RESP → next cycle all valids/readies are 0 and cmd_ready=1. A following read completes normally.
